// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 forms per-block candidate sums; stage 2 resolves the select chain and flags.
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NB = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < 2 * BLOCK) begin : g_bad_params
    $error("csel_adder_pipe: WIDTH must be a multiple of BLOCK and at least 2*BLOCK");
  end

  // ---------------- Stage 1: effective operands and block candidates
  logic [WIDTH-1:0]            bx;
  logic                        c0;
  logic [BLOCK:0]              blk0_d;
  logic [NB-1:1][BLOCK-1:0]    cand_s0_d, cand_s1_d;
  logic [NB-1:1]               cand_c0_d, cand_c1_d;
  logic [1:0]                  cmsb_d;

  assign bx     = sub ? ~B : B;
  assign c0     = sub | cin;
  assign blk0_d = {1'b0, A[BLOCK-1:0]} + {1'b0, bx[BLOCK-1:0]} + {{BLOCK{1'b0}}, c0};

  for (genvar k = 1; k < NB; k++) begin : g_cand
    logic [BLOCK:0] r0, r1;
    assign r0 = {1'b0, A[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]};
    assign r1 = r0 + {{BLOCK{1'b0}}, 1'b1};
    assign cand_s0_d[k] = r0[BLOCK-1:0];
    assign cand_c0_d[k] = r0[BLOCK];
    assign cand_s1_d[k] = r1[BLOCK-1:0];
    assign cand_c1_d[k] = r1[BLOCK];
  end

  // Carry into the MSB recovered from the top bit's sum for each top-block carry-in.
  assign cmsb_d[0] = A[WIDTH-1] ^ bx[WIDTH-1] ^ cand_s0_d[NB-1][BLOCK-1];
  assign cmsb_d[1] = A[WIDTH-1] ^ bx[WIDTH-1] ^ cand_s1_d[NB-1][BLOCK-1];

  // ---------------- Handshake
  logic s1_valid_q, out_valid_q;
  logic s2_free, accept, s1_advance;

  assign s2_free    = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_free;
  assign accept     = in_valid && in_ready;
  assign s1_advance = s1_valid_q && s2_free;

  // ---------------- Stage 1 payload registers
  logic [BLOCK:0]           s1_blk0_q;
  logic [NB-1:1][BLOCK-1:0] s1_s0_q, s1_s1_q;
  logic [NB-1:1]            s1_c0_q, s1_c1_q;
  logic [1:0]               s1_cmsb_q;

  // NOTE: payload registers carry no reset; s1_valid_q qualifies their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_blk0_q <= blk0_d;
      s1_s0_q   <= cand_s0_d;
      s1_s1_q   <= cand_s1_d;
      s1_c0_q   <= cand_c0_d;
      s1_c1_q   <= cand_c1_d;
      s1_cmsb_q <= cmsb_d;
    end
  end

  // ---------------- Stage 2: resolve the select chain
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d, msb_cin, carry;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum_d   = '0;
    msb_cin = 1'b0;
    carry   = s1_blk0_q[BLOCK];
    sum_d[BLOCK-1:0] = s1_blk0_q[BLOCK-1:0];
    for (int k = 1; k < NB; k++) begin
      if (k == NB - 1) msb_cin = carry ? s1_cmsb_q[1] : s1_cmsb_q[0];
      sum_d[k*BLOCK +: BLOCK] = carry ? s1_s1_q[k] : s1_s0_q[k];
      carry = carry ? s1_c1_q[k] : s1_c0_q[k];
    end
    cout_d = carry;
  end

  assign ovf_d  = msb_cin ^ cout_d;
  assign zero_d = (sum_d == '0);

  // ---------------- Control and result registers
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q  <= in_valid;
      if (s2_free)  out_valid_q <= s1_valid_q;
      if (s1_advance) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe: directed corner cases, handshake scenarios,
// and randomized traffic with backpressure against an arithmetic scoreboard.
module tb_csel_adder_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] A, B, sum;

  int           checks = 0;
  int           failures = 0;
  int           ov_cycles = 0;
  bit           rand_bp = 1'b0;
  logic [34:0]  exp_q[$];

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(32), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic, packed as {cout, ovf, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    longint      sa, sb, sres;
    logic [32:0] u;
    logic [31:0] r;
    logic        co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r    = a - b;
      co   = (a >= b);
      sres = sa - sb;
    end else begin
      u    = {1'b0, a} + {1'b0, b} + {32'd0, c};
      r    = u[31:0];
      co   = u[32];
      sres = sa + sb + longint'(c);
    end
    ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {co, ov, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: record accepts, compare every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        ov_cycles++;
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
        else begin
          check("result", {cout, ovf, zero, sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, cin, sub));
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Present one operand set and hold it until accepted (bounded); cyc = edges waited.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic s, output int cyc);
    bit f;
    int n = 0;
    in_valid = 1'b1; A = a; B = b; cin = c; sub = s;
    do begin
      @(negedge clk);
      f = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!f && n < 200);
    in_valid = 1'b0;
    cyc = n;
    check("push_accept", f, 1'b1);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [34:0] exp);
    int lat, cyc;
    push(a, b, c, s, cyc);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check(tag, {cout, ovf, zero, sum}, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;

    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", {cout, ovf, zero, sum}, 35'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Corner cases with hand-derived expectations {cout, ovf, zero, sum}
    directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    directed("add_cin",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
    directed("sub_borrow",32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});

    // Four back-to-back accepts with the consumer always ready
    ov_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      push($urandom, $urandom, 1'(i), 1'(i >> 1), cyc);
      check("b2b_in_ready", cyc, 1);
    end
    repeat (6) begin @(posedge clk); #1; end
    check("b2b_out_cycles", ov_cycles, 4);

    // Both stages fill while the consumer stalls, then drain in order
    out_ready = 1'b0;
    push($urandom, $urandom, 1'b0, 1'b0, cyc);
    push($urandom, $urandom, 1'b0, 1'b1, cyc);
    check("stall_in_ready", in_ready, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("stall_drained", exp_q.size(), 0);

    // Reset with both stages full, plus an operand offered during reset
    out_ready = 1'b0;
    push(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, cyc);
    push(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, cyc);
    rst_n = 1'b0; in_valid = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_outputs", {cout, ovf, zero, sum}, 35'd0);
    out_ready = 1'b1;
    ov_cycles = 0;
    repeat (8) begin @(posedge clk); #1; end
    check("post_rst_no_result", ov_cycles, 0);

    // Randomized traffic with random gaps and random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      push(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
CSEL_ADDER_PIPE -- requirements
Module: csel_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter BLOCK, default 4, carry-select block width in bits.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  operand set on A/B/cin/sub is valid.
REQ-006 Port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port A  input  WIDTH  operand A.
REQ-008 Port B  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in; add mode only.
REQ-010 Port sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-011 Port out_valid  output  1  result fields valid.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Port sum  output  WIDTH  result.
REQ-014 Port cout  output  1  carry out of MSB.
REQ-015 Port ovf  output  1  signed (two's-complement) overflow.
REQ-016 Port zero  output  1  sum == 0.

Function
REQ-017 WIDTH SHALL be an integer multiple of BLOCK and WIDTH >= 2*BLOCK; violation SHALL fail elaboration.
REQ-018 Effective operands SHALL be A, Bx = sub ? ~B : B, c0 = sub ? 1 : cin; cin ignored when sub=1.
REQ-019 Operand split into NB = WIDTH/BLOCK blocks; block 0 ripple-adds with c0; blocks 1..NB-1 each compute two candidates (carry-in 0 and 1): sum and carry-out.
REQ-020 Stage 1 (S1) SHALL register block-0 sum/carry, all candidate sums/carries, and the MSB carry-in candidates, on accept (in_valid && in_ready).
REQ-021 Stage 2 (S2) SHALL resolve the block select chain (block k uses carry-out of block k-1), register sum, cout, ovf = carry-into-MSB XOR cout, zero.
REQ-022 Latency: result SHALL be valid (out_valid=1) exactly 2 cycles after accept when no backpressure.
REQ-023 Throughput: one accept and one result per cycle when out_ready held 1.
REQ-024 s2_free = !out_valid || out_ready; in_ready = !s1_valid || s2_free; S1 advances into S2 only when s2_free.
REQ-025 While out_valid=1 and out_ready=0, sum/cout/ovf/zero SHALL hold stable.
REQ-026 Result order SHALL equal accept order; no drop, no duplicate.
REQ-027 Simultaneous S2 drain and S1 advance and new accept in one cycle SHALL all occur.
REQ-028 in_valid with in_ready=0 SHALL not be captured; A/B/cin/sub sampled only on accept.
REQ-029 Arithmetic modulo 2^WIDTH; sub cout = 1 means no borrow (A >= B unsigned).

Reset
REQ-030 rst_n=0 at a clock edge SHALL clear S1 and S2 valid flags; out_valid=0, in_ready=1 on the next cycle.
REQ-031 Reset values: sum=0, cout=0, ovf=0, zero=0.
REQ-032 Reset mid-operation SHALL discard all in-flight results; none emerges after reset release.
REQ-033 Input accepted in the same cycle rst_n=0 SHALL be discarded.

Verification (WIDTH=32, BLOCK=4)
REQ-034 add A=0xFFFFFFFF, B=0x00000001, cin=0 -> 2 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-035 add A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1, zero=0; same with cin=1, B=0 -> identical.
REQ-036 sub A=0x80000000, B=0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1; sub A=5, B=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 4 back-to-back accepts, out_ready=1 -> 4 consecutive out_valid cycles, results in order, in_ready stays 1.
REQ-038 two accepts then out_ready=0 for 3 cycles -> in_ready=0 from cycle after both stages full, sum stable; on out_ready=1 both results drain in order.
REQ-039 rst_n=0 for one cycle with S1 and S2 full -> out_valid=0, in_ready=1, no result appears after release.
